stack_mem_ctrl: RTL and testbench

STACK_MEM_CTRL -- requirements
Module: stack_mem_ctrl

---
 rtl/stack_pkg.sv | 13 +
 rtl/stack_mem_ctrl_if.sv | 32 +++
 rtl/stack_ram.sv | 20 ++
 rtl/stack_mem_ctrl.sv | 107 ++++++++++
 tb/tb_stack_mem_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared sizing and FSM state encoding for the stack memory controller.
package stack_pkg;
    localparam int DATA_W = 10;
    localparam int DEPTH  = 256;
    localparam int CNT_W  = 9;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        PUSH_SETTLE,
        POP_RESP
    } state_t;
endpackage

// File: rtl/stack_mem_ctrl_if.sv
// Push/pop handshake, SP block link and status bundle for stack_mem_ctrl.
interface stack_mem_ctrl_if #(
    parameter int DATA_W = stack_pkg::DATA_W
);
    logic [stack_pkg::ADDR_W-1:0] sp_addr;
    logic                         push_valid;
    logic [DATA_W-1:0]            push_data;
    logic                         push_ready;
    logic                         pop_valid;
    logic                         pop_ready;
    logic [DATA_W-1:0]            pop_data;
    logic                         pop_data_valid;
    logic                         sp_incr;
    logic                         sp_decr;
    logic [stack_pkg::CNT_W-1:0]  stk_count;
    logic                         stk_full;
    logic                         stk_empty;
    logic                         err_ovf;
    logic                         err_unf;

    modport master (
        output sp_addr, push_valid, push_data, pop_valid,
        input  push_ready, pop_ready, pop_data, pop_data_valid,
        input  sp_incr, sp_decr, stk_count, stk_full, stk_empty, err_ovf, err_unf
    );

    modport slave (
        input  sp_addr, push_valid, push_data, pop_valid,
        output push_ready, pop_ready, pop_data, pop_data_valid,
        output sp_incr, sp_decr, stk_count, stk_full, stk_empty, err_ovf, err_unf
    );
endinterface

// File: rtl/stack_ram.sv
// Single-port stack storage: synchronous write, registered read, no reset.
module stack_ram #(
    parameter int DATA_W = stack_pkg::DATA_W,
    parameter int DEPTH  = stack_pkg::DEPTH,
    parameter int ADDR_W = stack_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_p1
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata_p1 <= mem[addr];
    end
endmodule

// File: rtl/stack_mem_ctrl.sv
// Stack controller: push/pop handshake FSM, occupancy counter, sticky error
// flags and SP increment/decrement pulses around a single-port RAM.
module stack_mem_ctrl #(
    parameter int DATA_W = stack_pkg::DATA_W,
    parameter int DEPTH  = stack_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    stack_mem_ctrl_if.slave  bus
);
    import stack_pkg::*;

    state_t              state, state_nxt;
    logic                push_ready, pop_ready;
    logic                push_acc, pop_acc;
    logic                ovf_hit, unf_hit;
    logic                full, empty;
    logic [CNT_W-1:0]    count;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_rd_p1;
    logic [DATA_W-1:0]   pop_hold;
    logic                ovf, unf;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        push_ready = 1'b0;
        pop_ready  = 1'b0;
        push_acc   = 1'b0;
        pop_acc    = 1'b0;
        ovf_hit    = 1'b0;
        unf_hit    = 1'b0;
        case (state)
            IDLE: begin
                // Push has priority: a pending push masks pop_ready entirely.
                push_ready = !full;
                pop_ready  = !empty && !bus.push_valid;
                push_acc   = bus.push_valid && push_ready;
                pop_acc    = bus.pop_valid && pop_ready;
                ovf_hit    = bus.push_valid && full;
                unf_hit    = bus.pop_valid && !bus.push_valid && empty;
                if (push_acc)     state_nxt = PUSH_SETTLE;
                else if (pop_acc) state_nxt = POP_RESP;
            end
            PUSH_SETTLE: state_nxt = IDLE;
            POP_RESP:    state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // Stack grows downward: push writes below the current SP, pop reads at SP.
    assign ram_addr = push_acc ? (bus.sp_addr - ADDR_W'(1)) : bus.sp_addr;

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .we       (push_acc),
        .re       (pop_acc),
        .addr     (ram_addr),
        .wdata    (bus.push_data),
        .rdata_p1 (ram_rd_p1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           count <= '0;
        else if (push_acc) count <= count + CNT_W'(1);
        else if (pop_acc)  count <= count - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (ovf_hit) ovf <= 1'b1;
            if (unf_hit) unf <= 1'b1;
        end
    end

    // Hold register keeps pop_data stable between responses and zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  pop_hold <= '0;
        else if (state == POP_RESP) pop_hold <= ram_rd_p1;
    end

    assign bus.push_ready     = push_ready;
    assign bus.pop_ready      = pop_ready;
    assign bus.sp_decr        = (state == PUSH_SETTLE);
    assign bus.sp_incr        = (state == POP_RESP);
    assign bus.pop_data_valid = (state == POP_RESP);
    assign bus.pop_data       = (state == POP_RESP) ? ram_rd_p1 : pop_hold;
    assign bus.stk_count      = count;
    assign bus.stk_full       = full;
    assign bus.stk_empty      = empty;
    assign bus.err_ovf        = ovf;
    assign bus.err_unf        = unf;
endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Self-checking bench for stack_mem_ctrl with a modelled SP block.
module tb_stack_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] sp;

    int checks = 0;
    int errors = 0;

    stack_mem_ctrl_if #(.DATA_W(10)) bus ();

    stack_mem_ctrl #(.DATA_W(10), .DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // SP block model, reset together with the controller.
    always @(posedge clk or posedge rst) begin
        if (rst)              sp <= 8'd0;
        else if (bus.sp_decr) sp <= sp - 8'd1;
        else if (bus.sp_incr) sp <= sp + 8'd1;
    end
    assign bus.sp_addr = sp;

    typedef struct packed {
        logic       push_v;
        logic       pop_v;
        logic [9:0] data;
        logic [8:0] exp_cnt;
        logic       exp_pdv;
        logic [9:0] exp_pd;
    } vec_t;

    vec_t vecs [30];

    logic [9:0] m_stk [$];
    logic [9:0] exp_q [$];
    int         m_cnt;
    logic       m_busy, m_ovf, m_unf;
    logic [9:0] m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_stk.delete();
        exp_q.delete();
        m_cnt  = 0;
        m_busy = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_last = 10'd0;
    endtask

    // One clock: predict handshake, advance, then check all outputs at negedge.
    task automatic tick();
        logic pa, qa, exp_pr, exp_qr;
        logic [9:0] d;
        #1;
        exp_pr = !m_busy && (m_cnt != 256);
        exp_qr = !m_busy && (m_cnt != 0) && !bus.push_valid;
        check("push_ready", 32'(bus.push_ready), 32'(exp_pr));
        check("pop_ready", 32'(bus.pop_ready), 32'(exp_qr));
        pa = bus.push_valid && exp_pr;
        qa = bus.pop_valid && exp_qr;
        if (!m_busy && bus.push_valid && m_cnt == 256) m_ovf = 1'b1;
        if (!m_busy && bus.pop_valid && !bus.push_valid && m_cnt == 0) m_unf = 1'b1;
        if (pa) begin
            m_stk.push_back(bus.push_data);
            m_cnt++;
        end
        if (qa && m_stk.size() > 0) begin
            exp_q.push_back(m_stk.pop_back());
            m_cnt--;
        end
        m_busy = pa || qa;
        @(posedge clk);
        @(negedge clk);
        check("pop_data_valid", 32'(bus.pop_data_valid), 32'(qa));
        check("sp_decr", 32'(bus.sp_decr), 32'(pa));
        check("sp_incr", 32'(bus.sp_incr), 32'(qa));
        check("stk_count", 32'(bus.stk_count), 32'(m_cnt));
        check("stk_full", 32'(bus.stk_full), 32'(m_cnt == 256));
        check("stk_empty", 32'(bus.stk_empty), 32'(m_cnt == 0));
        check("err_ovf", 32'(bus.err_ovf), 32'(m_ovf));
        check("err_unf", 32'(bus.err_unf), 32'(m_unf));
        if (bus.pop_data_valid) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'(bus.pop_data_valid), 32'd0);
            end else begin
                d = exp_q.pop_front();
                check("pop_data", 32'(bus.pop_data), 32'(d));
                m_last = d;
            end
        end else begin
            check("pop_data_hold", 32'(bus.pop_data), 32'(m_last));
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 10'h155, 9'd1, 1'b0, 10'h000};
        vecs[1]  = '{1'b1, 1'b0, 10'h3FF, 9'd1, 1'b0, 10'h000};
        vecs[2]  = '{1'b0, 1'b1, 10'h000, 9'd0, 1'b1, 10'h155};
        vecs[3]  = '{1'b0, 1'b0, 10'h000, 9'd0, 1'b0, 10'h000};
        vecs[4]  = '{1'b1, 1'b0, 10'h001, 9'd1, 1'b0, 10'h000};
        vecs[5]  = '{1'b0, 1'b0, 10'h000, 9'd1, 1'b0, 10'h000};
        vecs[6]  = '{1'b1, 1'b0, 10'h002, 9'd2, 1'b0, 10'h000};
        vecs[7]  = '{1'b0, 1'b0, 10'h000, 9'd2, 1'b0, 10'h000};
        vecs[8]  = '{1'b1, 1'b0, 10'h003, 9'd3, 1'b0, 10'h000};
        vecs[9]  = '{1'b0, 1'b0, 10'h000, 9'd3, 1'b0, 10'h000};
        vecs[10] = '{1'b0, 1'b1, 10'h000, 9'd2, 1'b1, 10'h003};
        vecs[11] = '{1'b0, 1'b0, 10'h000, 9'd2, 1'b0, 10'h000};
        vecs[12] = '{1'b0, 1'b1, 10'h000, 9'd1, 1'b1, 10'h002};
        vecs[13] = '{1'b0, 1'b0, 10'h000, 9'd1, 1'b0, 10'h000};
        vecs[14] = '{1'b0, 1'b1, 10'h000, 9'd0, 1'b1, 10'h001};
        vecs[15] = '{1'b0, 1'b0, 10'h000, 9'd0, 1'b0, 10'h000};
        vecs[16] = '{1'b1, 1'b0, 10'h0AA, 9'd1, 1'b0, 10'h000};
        vecs[17] = '{1'b0, 1'b0, 10'h000, 9'd1, 1'b0, 10'h000};
        vecs[18] = '{1'b1, 1'b0, 10'h0BB, 9'd2, 1'b0, 10'h000};
        vecs[19] = '{1'b0, 1'b0, 10'h000, 9'd2, 1'b0, 10'h000};
        vecs[20] = '{1'b1, 1'b1, 10'h0CC, 9'd3, 1'b0, 10'h000};
        vecs[21] = '{1'b0, 1'b0, 10'h000, 9'd3, 1'b0, 10'h000};
        vecs[22] = '{1'b0, 1'b1, 10'h000, 9'd2, 1'b1, 10'h0CC};
        vecs[23] = '{1'b0, 1'b1, 10'h000, 9'd2, 1'b0, 10'h000};
        vecs[24] = '{1'b0, 1'b1, 10'h000, 9'd1, 1'b1, 10'h0BB};
        vecs[25] = '{1'b0, 1'b0, 10'h000, 9'd1, 1'b0, 10'h000};
        vecs[26] = '{1'b0, 1'b1, 10'h000, 9'd0, 1'b1, 10'h0AA};
        vecs[27] = '{1'b0, 1'b0, 10'h000, 9'd0, 1'b0, 10'h000};
        vecs[28] = '{1'b0, 1'b1, 10'h000, 9'd0, 1'b0, 10'h000};
        vecs[29] = '{1'b0, 1'b0, 10'h000, 9'd0, 1'b0, 10'h000};

        bus.push_valid = 1'b0;
        bus.push_data  = 10'd0;
        bus.pop_valid  = 1'b0;
        model_clear();

        repeat (2) @(negedge clk);
        check("rst_count", 32'(bus.stk_count), 32'd0);
        check("rst_empty", 32'(bus.stk_empty), 32'd1);
        check("rst_full", 32'(bus.stk_full), 32'd0);
        check("rst_pdv", 32'(bus.pop_data_valid), 32'd0);
        check("rst_pop_data", 32'(bus.pop_data), 32'd0);
        check("rst_errs", 32'({bus.err_ovf, bus.err_unf}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            bus.push_valid = vecs[i].push_v;
            bus.pop_valid  = vecs[i].pop_v;
            bus.push_data  = vecs[i].data;
            tick();
            check($sformatf("vec%0d_cnt", i), 32'(bus.stk_count), 32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_pdv", i), 32'(bus.pop_data_valid), 32'(vecs[i].exp_pdv));
            if (vecs[i].exp_pdv)
                check($sformatf("vec%0d_pd", i), 32'(bus.pop_data), 32'(vecs[i].exp_pd));
            if (i == 1)
                check("sp_after_push", 32'(sp), 32'hFF);
        end
        bus.push_valid = 1'b0;
        bus.pop_valid  = 1'b0;
        check("unf_sticky", 32'(bus.err_unf), 32'd1);
        check("ovf_clear", 32'(bus.err_ovf), 32'd0);

        // Fill to capacity, then overflow attempt.
        for (int i = 0; i < 256; i++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = 10'(i * 3 + 7);
            tick();
            bus.push_valid = 1'b0;
            tick();
        end
        check("full_flag", 32'(bus.stk_full), 32'd1);
        check("full_sp", 32'(sp), 32'd0);
        bus.push_valid = 1'b1;
        bus.push_data  = 10'h2AA;
        tick();
        bus.push_valid = 1'b0;
        check("ovf_set", 32'(bus.err_ovf), 32'd1);
        check("ovf_count", 32'(bus.stk_count), 32'd256);
        check("ovf_sp", 32'(sp), 32'd0);
        check("ovf_ready", 32'(bus.push_ready), 32'd0);

        // Pop accepted, then reset while the response is on the bus.
        bus.pop_valid = 1'b1;
        tick();
        bus.pop_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid_pdv", 32'(bus.pop_data_valid), 32'd0);
        check("rstmid_incr", 32'(bus.sp_incr), 32'd0);
        check("rstmid_count", 32'(bus.stk_count), 32'd0);
        check("rstmid_empty", 32'(bus.stk_empty), 32'd1);
        check("rstmid_errs", 32'({bus.err_ovf, bus.err_unf}), 32'd0);
        check("rstmid_pop_data", 32'(bus.pop_data), 32'd0);
        check("rstmid_idle", 32'(bus.push_ready), 32'd1);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_sp", 32'(sp), 32'd0);
        tick();
        bus.pop_valid = 1'b1;
        tick();
        bus.pop_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
